// File: rtl/ws2812_frame_sched.sv
// Round-robin frame scheduler feeding the ws2812 driver: latches the winning frame, kicks the driver,
// tracks its busy handshake and enforces a refresh interval. Optional skip of identical frames: WS_SCHED_SKIP_SAME_EN.
module ws2812_frame_sched #(
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned NUM_LEDS     = 256,
   parameter int unsigned MIN_PERIOD   = 400_000,
   parameter int unsigned BUSY_TIMEOUT = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*NUM_LEDS-1:0]  frame_in,
   output logic [NUM_REQ-1:0]           grant,
   output logic [NUM_REQ-1:0]           done,
   output logic                         err,
   output logic [NUM_LEDS-1:0]          frame_out,
   output logic                         drv_update,
   input  logic                         drv_busy,
   output logic                         sched_busy
);

   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned PW = $clog2(MIN_PERIOD + 1);
   localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LATCH, S_KICK, S_WAIT_BUSY, S_WAIT_DONE, S_FINISH
   } state_t;

   state_t            state, state_nxt;
   logic [IW-1:0]     ptr, winner, pick;
   logic              pick_valid;
   logic [PW-1:0]     period_cnt;
   logic [TW-1:0]     to_cnt;
   logic              take, skip_same, skip_path;
   logic [NUM_REQ-1:0] grant_nxt, done_nxt;
   logic              err_nxt, drv_update_nxt, sched_busy_nxt;

   // Round-robin search from ptr+1; nearest requester wins (last assignment).
   always_comb begin
      logic [IW-1:0] cand;
      pick       = ptr;
      pick_valid = 1'b0;
      for (int unsigned i = NUM_REQ; i >= 1; i--) begin
         cand = IW'((32'(ptr) + i) % NUM_REQ);
         if (req[cand]) begin
            pick       = cand;
            pick_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:      if (pick_valid && period_cnt == '0) state_nxt = S_LATCH;
         S_LATCH:     state_nxt = skip_same ? S_FINISH : S_KICK;
         S_KICK:      state_nxt = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (drv_busy)                 state_nxt = S_WAIT_DONE;
            else if (to_cnt == TW'(1))    state_nxt = S_FINISH;
         end
         S_WAIT_DONE: if (!drv_busy) state_nxt = S_FINISH;
         S_FINISH:    state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs, keyed on the state being entered.
   always_comb begin
      take           = (state == S_IDLE) && (state_nxt == S_LATCH);
      grant_nxt      = take ? (NUM_REQ'(1) << pick) : '0;
      drv_update_nxt = (state_nxt == S_KICK);
      done_nxt       = (state_nxt == S_FINISH) ? (NUM_REQ'(1) << winner) : '0;
      err_nxt        = (state == S_WAIT_BUSY) && !drv_busy && (to_cnt == TW'(1));
      sched_busy_nxt = (state_nxt != S_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr        <= IW'(NUM_REQ - 1);
         winner     <= '0;
         period_cnt <= '0;
         to_cnt     <= '0;
         skip_path  <= 1'b0;
         frame_out  <= '0;
         grant      <= '0;
         done       <= '0;
         err        <= 1'b0;
         drv_update <= 1'b0;
         sched_busy <= 1'b0;
      end else begin
         grant      <= grant_nxt;
         done       <= done_nxt;
         err        <= err_nxt;
         drv_update <= drv_update_nxt;
         sched_busy <= sched_busy_nxt;
         if (take) begin
            ptr       <= pick;
            winner    <= pick;
            frame_out <= frame_in[32'(pick) * NUM_LEDS +: NUM_LEDS];
         end
         if (state == S_LATCH) skip_path <= skip_same;
         if (state == S_KICK)
            to_cnt <= TW'(BUSY_TIMEOUT);
         else if (state == S_WAIT_BUSY && to_cnt != '0)
            to_cnt <= to_cnt - 1'b1;
         // A skipped (identical) frame leaves the refresh interval untouched.
         if (state == S_FINISH && !skip_path)
            period_cnt <= PW'(MIN_PERIOD);
         else if (period_cnt != '0)
            period_cnt <= period_cnt - 1'b1;
      end
   end

`ifdef WS_SCHED_SKIP_SAME_EN
   logic [NUM_LEDS-1:0] prev_frame;
   logic                xfer_seen;

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_frame <= '0;
         xfer_seen  <= 1'b0;
      end else begin
         if (take) prev_frame <= frame_out;
         if (state == S_FINISH && !skip_path) xfer_seen <= 1'b1;
      end
   end

   assign skip_same = xfer_seen && (frame_out == prev_frame);
`else
   assign skip_same = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Randomized bench for ws2812_frame_sched: a transaction-level timeline model predicts every output each cycle.
`timescale 1ns/1ps
module tb_ws2812_frame_sched;
   localparam int unsigned NR = 2;
   localparam int unsigned NL = 256;
   localparam int unsigned MP = 16;
   localparam int unsigned BT = 8;

   logic             clock = 1'b0;
   logic             reset;
   logic [NR-1:0]    req;
   logic [NR*NL-1:0] frame_in;
   logic [NR-1:0]    grant, done;
   logic             err;
   logic [NL-1:0]    frame_out;
   logic             drv_update, drv_busy, sched_busy;

   ws2812_frame_sched #(.NUM_REQ(NR), .NUM_LEDS(NL), .MIN_PERIOD(MP), .BUSY_TIMEOUT(BT)) dut (
      .clock(clock), .reset(reset), .req(req), .frame_in(frame_in), .grant(grant), .done(done),
      .err(err), .frame_out(frame_out), .drv_update(drv_update), .drv_busy(drv_busy),
      .sched_busy(sched_busy));

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int k = 0;

   // stimulus knobs
   logic             reset_d;
   logic [NR-1:0]    req_d;
   logic [NR*NL-1:0] frame_d;
   bit               rand_frames;
   int               busy_mode, fix_d, fix_l;

   // model: one transaction timeline (grant cycle, done cycle, driver busy window)
   bit            m_valid, m_err, m_skip, m_seen;
   int            m_ptr, m_w, m_tg, m_td, m_bs, m_be, m_ready;
   logic [NL-1:0] m_frame, m_fexp;

   int og_cyc[$], og_w[$], od_cyc[$], od_w[$], od_err[$], ou_cyc[$];

   task automatic chk(input string name, input logic [NL-1:0] act, input logic [NL-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, k, act, exp);
      end
   endtask

   function automatic logic [NR-1:0] oh(input int i);
      return NR'(1) << i;
   endfunction

   function automatic int idx_of(input logic [NR-1:0] v);
      for (int i = 0; i < int'(NR); i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [NR*NL-1:0] rnd_frames();
      logic [NR*NL-1:0] f;
      for (int i = 0; i < int'(NR*NL/32); i++) f[i*32 +: 32] = $urandom;
      return f;
   endfunction

   task automatic decide();
      int w, c, d, l, mode;
      w = -1;
      for (int i = 1; i <= int'(NR); i++) begin
         c = (m_ptr + i) % int'(NR);
         if (w < 0 && req_d[c]) w = c;
      end
      m_ptr = w; m_w = w; m_tg = k + 1; m_valid = 1; m_err = 0; m_bs = 0; m_be = 0;
      m_frame = frame_d[w*NL +: NL];
`ifdef WS_SCHED_SKIP_SAME_EN
      m_skip = m_seen && (m_frame == m_fexp);
`else
      m_skip = 0;
`endif
      if (m_skip) m_td = k + 2;
      else begin
         mode = busy_mode;
         if (mode == 0) mode = ($urandom_range(0, 5) == 0) ? 2 : 3;
         if (mode == 2) begin
            m_td = k + 3 + int'(BT);
            m_err = 1;
         end else begin
            if (mode == 1) begin d = fix_d; l = fix_l; end
            else begin d = $urandom_range(0, BT - 1); l = $urandom_range(1, 12); end
            m_bs = k + 3 + d;
            m_be = m_bs + l;
            m_td = k + 4 + d + l;
         end
         m_ready = m_td + int'(MP) + 1;
         m_seen = 1;
      end
   endtask

   // One clock cycle: compare outputs of cycle k, drive inputs for cycle k, advance the model.
   task automatic step();
      logic [NR-1:0] eg, ed;
      logic          eu, ee, eb;
      @(negedge clock);
      if (k >= 1) begin
         if (m_valid && k == m_tg) m_fexp = m_frame;
         eg = (m_valid && k == m_tg) ? oh(m_w) : '0;
         eu = m_valid && !m_skip && k == m_tg + 1;
         ed = (m_valid && k == m_td) ? oh(m_w) : '0;
         ee = m_valid && m_err && k == m_td;
         eb = m_valid && k >= m_tg && k <= m_td;
         chk("grant", grant, eg);
         chk("drv_update", drv_update, eu);
         chk("done", done, ed);
         chk("err", err, ee);
         chk("sched_busy", sched_busy, eb);
         chk("frame_out", frame_out, m_fexp);
         if (grant != '0) begin og_cyc.push_back(k); og_w.push_back(idx_of(grant)); end
         if (done != '0) begin od_cyc.push_back(k); od_w.push_back(idx_of(done)); od_err.push_back(int'(err)); end
         if (drv_update) ou_cyc.push_back(k);
      end
      reset = reset_d;
      req   = req_d;
      if (rand_frames) frame_d = rnd_frames();
      frame_in = frame_d;
      drv_busy = (k >= m_bs && k < m_be);
      if (reset_d) begin
         m_valid = 0; m_ptr = NR - 1; m_ready = k + 1; m_seen = 0; m_fexp = '0; m_bs = 0; m_be = 0;
      end else if ((!m_valid || k > m_td) && k >= m_ready && req_d != '0) begin
         decide();
      end
      k++;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic run_to(input int c);
      while (k < c) step();
   endtask

   task automatic wait_grant(input string nm, input int lim);
      int n0, t;
      n0 = og_cyc.size();
      t = 0;
      while (og_cyc.size() == n0 && t < lim) begin step(); t++; end
      if (og_cyc.size() == n0) begin
         checks++; errors++;
         $display("FAIL %s: no grant within %0d cycles, got none, expected one", nm, lim);
      end
   endtask

   function automatic int qv(input int q[$], input int i);
      return (i >= 0 && i < q.size()) ? q[i] : -999;
   endfunction

   initial begin
      logic [NL-1:0] f0;
      int gb, db, ng, n0, r, nu;
      reset = 1'b1; req = '0; drv_busy = 1'b0; frame_in = '0;
      reset_d = 1'b1; req_d = '0; frame_d = '0; rand_frames = 0;
      busy_mode = 1; fix_d = 0; fix_l = 100;

      // reset, then single request at cycle 10 with a 100-cycle busy from cycle 13
      run(3);
      reset_d = 1'b0;
      frame_d = rnd_frames();
      f0 = frame_d[0 +: NL];
      run_to(10);
      req_d = 2'b01; step(); req_d = '0;
      run_to(130);
      chk("single_grant_cycle", 256'(qv(og_cyc, 0)), 256'(11));
      chk("single_grant_id", 256'(qv(og_w, 0)), 256'(0));
      chk("single_update_cycle", 256'(qv(ou_cyc, 0)), 256'(12));
      chk("single_done_cycle", 256'(qv(od_cyc, 0)), 256'(114));
      chk("single_done_err", 256'(qv(od_err, 0)), 256'(0));
      chk("single_frame_held", frame_out, f0);

      // busy never rises: done+err BT+1 cycles after drv_update
      frame_d = rnd_frames();
      busy_mode = 2;
      run_to(140);
      req_d = 2'b01; step(); req_d = '0;
      run_to(170);
      chk("timeout_update_cycle", 256'(qv(ou_cyc, 1)), 256'(142));
      chk("timeout_done_cycle", 256'(qv(od_cyc, 1)), 256'(151));
      chk("timeout_latency", 256'(qv(od_cyc, 1) - qv(ou_cyc, 1)), 256'(BT + 1));
      chk("timeout_err", 256'(qv(od_err, 1)), 256'(1));
      chk("timeout_idle", sched_busy, 256'(0));

      // both requesting: strict alternation and minimum done->grant spacing
      busy_mode = 0; rand_frames = 1;
      gb = og_cyc.size(); db = od_cyc.size();
      req_d = 2'b11; run(300); req_d = '0; run(60);
      ng = og_cyc.size() - gb;
      chk("rr_count_ge4", 256'(ng >= 4), 256'(1));
      chk("rr_balance", 256'(od_cyc.size() - db), 256'(ng));
      chk("rr_first", 256'(qv(og_w, gb)), 256'(1));
      for (int i = gb + 1; i < og_cyc.size(); i++) begin
         chk("rr_alternate", 256'(qv(og_w, i)), 256'((qv(og_w, i - 1) + 1) % int'(NR)));
         chk("rr_gap", 256'(qv(og_cyc, i) - qv(od_cyc, db + (i - gb) - 1) - 1), 256'(MP + 1));
      end

      // req[1] pulsed while a transfer is in WAIT_DONE is never granted
      rand_frames = 0; frame_d = rnd_frames();
      busy_mode = 1; fix_d = 0; fix_l = 30;
      req_d = 2'b01;
      wait_grant("withdraw_first", 200);
      run(5);
      req_d = 2'b11; step(); req_d = 2'b01;
      wait_grant("withdraw_next", 200);
      chk("withdraw_winner", 256'(qv(og_w, og_w.size() - 1)), 256'(0));
      req_d = '0; run(60);

      // reset during WAIT_DONE: outputs clear, no done, req[1] re-granted immediately
      frame_d = rnd_frames(); fix_l = 40;
      req_d = 2'b10;
      wait_grant("reset_first", 200);
      run(5);
      n0 = od_cyc.size();
      reset_d = 1'b1; r = k; step(); reset_d = 1'b0;
      @(posedge clock); #1;
      chk("reset_frame_out", frame_out, 256'(0));
      chk("reset_sched_busy", sched_busy, 256'(0));
      chk("reset_done", done, 256'(0));
      wait_grant("reset_regrant", 10);
      chk("reset_regrant_cycle", 256'(qv(og_cyc, og_cyc.size() - 1)), 256'(r + 2));
      chk("reset_regrant_id", 256'(qv(og_w, og_w.size() - 1)), 256'(1));
      chk("reset_no_done", 256'(od_cyc.size()), 256'(n0));
      req_d = '0; run(80);

      // random traffic, random frames, random driver behaviour, rare resets
      busy_mode = 0; rand_frames = 1;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 7) == 0) req_d = NR'($urandom);
         reset_d = ($urandom_range(0, 399) == 0);
         step();
      end
      reset_d = 1'b0; req_d = '0; run(60);

`ifdef WS_SCHED_SKIP_SAME_EN
      // identical frame after a completed transfer is skipped; a changed frame is not
      rand_frames = 0; busy_mode = 1; fix_d = 1; fix_l = 5;
      frame_d = rnd_frames();
      req_d = 2'b01; wait_grant("skip_first", 100); req_d = '0; run(40);
      nu = ou_cyc.size();
      req_d = 2'b01; wait_grant("skip_same", 100); req_d = '0; run(5);
      chk("skip_done_latency", 256'(qv(od_cyc, od_cyc.size() - 1) - qv(og_cyc, og_cyc.size() - 1)), 256'(1));
      chk("skip_no_update", 256'(ou_cyc.size()), 256'(nu));
      frame_d = rnd_frames();
      req_d = 2'b01; wait_grant("skip_changed", 100); req_d = '0; run(40);
      chk("skip_changed_update", 256'(ou_cyc.size()), 256'(nu + 1));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ws2812_frame_sched.md
# ws2812_frame_sched

Frame scheduler between the display producers (game matrix, IMU debug view, etc.) and the `ws2812_inner` LED driver. It round-robin arbitrates among `NUM_REQ` frame requesters and latches the winner's 1-bit-per-LED frame into a stable output buffer. It then issues a single-cycle update to the driver, tracks the driver's busy handshake to completion, and enforces a minimum interval between refreshes.

## Interface
Parameters:
- `NUM_REQ`, 2: number of frame requesters (2..4).
- `NUM_LEDS`, 256: frame width in LEDs, one bit each.
- `MIN_PERIOD`, 400_000: minimum cycles from one transfer's completion to the next transfer's start (20 ms at 20 MHz).
- `BUSY_TIMEOUT`, 8: cycles allowed for `drv_busy` to rise after `drv_update`.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `req`  in  NUM_REQ  per-requester frame request, level.
- `frame_in`  in  NUM_REQ*NUM_LEDS  requester i's frame at bits [i*NUM_LEDS +: NUM_LEDS].
- `grant`  out  NUM_REQ  one-hot, 1-cycle pulse: frame sampled.
- `done`  out  NUM_REQ  one-hot, 1-cycle pulse: transfer finished.
- `err`  out  1  1-cycle pulse with `done` on busy timeout.
- `frame_out`  out  NUM_LEDS  latched frame presented to driver color mapping.
- `drv_update`  out  1  1-cycle start pulse to driver.
- `drv_busy`  in  1  driver busy (includes latch time).
- `sched_busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LATCH, KICK, WAIT_BUSY, WAIT_DONE, FINISH.
- IDLE:
  - If any `req` is high and `period_cnt == 0`, select the winner.
  - Register `frame_out` from the winner's slice and register `grant[winner]`.
  - Update the RR pointer to the winner and go to LATCH.
- Round-robin search starts at `ptr+1` mod `NUM_REQ`. `ptr` resets to `NUM_REQ-1`, so requester 0 wins first.
- LATCH: `grant` is high for this cycle. Go to KICK.
- KICK: `drv_update` is high for this cycle. Load `to_cnt = BUSY_TIMEOUT`. Go to WAIT_BUSY.
- WAIT_BUSY:
  - If `drv_busy` is high, go to WAIT_DONE.
  - Otherwise, if `to_cnt == 1`, set the `err` flag and go to FINISH.
  - Otherwise, decrement `to_cnt`.
- WAIT_DONE: when `drv_busy` is sampled low, go to FINISH.
- FINISH:
  - `done[winner]` is high for this cycle; `err` is high if the timeout path was taken.
  - Load `period_cnt = MIN_PERIOD`. Go to IDLE.
- `period_cnt` counts down by 1 per cycle, saturating at 0. Its reset value is 0, so the first frame is not delayed.
- `frame_in` is sampled only at the IDLE→LATCH edge. `frame_out` is held constant until the next grant.
- A requester may drop `req` before `grant`; this withdraws the request with no side effect. `req` held through `done` re-requests, and that requester participates in the next arbitration as normal.
- `req` changes during LATCH..FINISH are ignored.
- Reset values:
  - State IDLE; `ptr = NUM_REQ-1`; `period_cnt = 0`.
  - `frame_out = 0`.
  - `grant`, `done`, `err`, `drv_update`, `sched_busy` = 0.
- Reset mid-transfer returns to IDLE immediately; no `done` is issued. The driver shares the same reset.

## Timing
- With `req` high in IDLE cycle N and `period_cnt == 0`:
  - `grant` is high in N+1.
  - `drv_update` is high in N+2.
  - `drv_busy` is first examined in N+3.
- `done` is high in the cycle after `drv_busy` is first sampled low in WAIT_DONE.
- Minimum gap between `done` and the next `grant` is `MIN_PERIOD+1` cycles.
- Timeout path: `done`/`err` fall `BUSY_TIMEOUT+1` cycles after `drv_update`.
- `sched_busy` is registered and high from N+1 through the FINISH cycle inclusive.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `WS_SCHED_SKIP_SAME_EN` defined:
  - In LATCH, if the newly latched frame equals the previous `frame_out` and at least one transfer has completed since reset, skip KICK/WAIT states and go directly to FINISH.
  - On this skip path, `done` pulses at N+2, `drv_update` is never asserted, and `period_cnt` is not reloaded.
- `WS_SCHED_SKIP_SAME_EN` not defined: every grant produces a full driver transfer.

## Test plan
- Single request, `MIN_PERIOD=16`: `req[0]=1` at cycle 10 → `grant[0]` @11, `drv_update` @12. Model busy 100 cycles from @13 → `done[0]` one cycle after busy falls, `frame_out` equals `frame_in[0]` slice.
- Round-robin: `req=2'b11` held continuously → grants alternate 0,1,0,1. Consecutive `done`→`grant` gaps are exactly `MIN_PERIOD+1`.
- Timeout: driver never raises busy → `done[0]` and `err` together 9 cycles after `drv_update` (`BUSY_TIMEOUT=8`), then return to IDLE.
- Reset mid-transfer: assert `reset` in WAIT_DONE → next cycle all outputs 0, `frame_out=0`, no `done`. The next `req[1]` is granted with no period wait.
- Withdrawal: `req[1]` pulsed for one cycle while the scheduler is in WAIT_DONE → never granted; `req[0]` still wins next.
- With `WS_SCHED_SKIP_SAME_EN`: resend an identical frame after a completed transfer → `done` 2 cycles after the IDLE decision, no `drv_update`. A changed frame → normal full transfer.
